// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory port, the redirect port and
// the instruction-queue output handshake of the fetch unit.
//   imem_req/imem_addr   -> request to instruction memory (addr word aligned)
//   imem_rdata           <- instruction word, one cycle after the request
//   redirect/redirect_pc <- taken branch/jump, flushes the unit
//   out_valid/instr/pc   -> queue head
//   out_ready            <- consumer accepts the head
// master = fetch unit side, slave = memory/pipeline side.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;

  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_rdata, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_rdata, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetcher with a DEPTH-entry instruction
// queue and credit-based issue (queued + in-flight never exceeds DEPTH, so a
// response always finds a free slot). Redirect flushes everything and restarts
// fetch at the aligned redirect_pc; reset restarts at RESET_PC.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - fetch_unit_if.master (imem request/response, redirect, out handshake)
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   infl_pc_q, infl_pc_d;
  logic          infl_q, infl_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  entry_t        mem_q [DEPTH];

  logic          issue, wr_en, pop;
  logic [CW:0]   credits_used;
  logic          unused_rpc;

  // Low address bits of the redirect target are forced to zero.
  assign unused_rpc = ^bus.redirect_pc[1:0];

  // Credits use registered occupancy only; a same-cycle pop frees its slot
  // for issue one cycle later.
  assign credits_used = {1'b0, count_q} + {{CW{1'b0}}, infl_q};
  assign issue        = !rst && !bus.redirect && (credits_used < DEPTH_C);
  assign wr_en        = infl_q && !bus.redirect;
  assign pop          = bus.out_valid && bus.out_ready;

  assign bus.imem_req  = issue;
  assign bus.imem_addr = fetch_pc_q;

  // Masked during reset so nothing is presented while the unit is held.
  assign bus.out_valid = (count_q != '0) && !rst;
  assign bus.out_pc    = mem_q[rd_ptr_q].pc;
  assign bus.out_instr = mem_q[rd_ptr_q].instr;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    infl_pc_d  = infl_pc_q;
    infl_d     = infl_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (bus.redirect) begin
      // Flush: queued entries and the pending response are dropped, a
      // coincident pop is simply absorbed by the flush.
      fetch_pc_d = {bus.redirect_pc[31:2], 2'b00};
      infl_d     = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      infl_d = issue;
      if (issue) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
        infl_pc_d  = fetch_pc_q;
      end
      if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      infl_pc_q  <= '0;
      infl_q     <= 1'b0;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      infl_pc_q  <= infl_pc_d;
      infl_q     <= infl_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem_q[wr_ptr_q] <= '{pc: infl_pc_q, instr: bus.imem_rdata};
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for fetch_unit with a queue-level
// reference model checked every cycle, plus literal expectations per scenario.
module tb_fetch_unit;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] K        = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus();
  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  // Instruction memory: word returned one cycle after the request.
  always_ff @(posedge clk)
    bus.imem_rdata <= bus.imem_req ? (bus.imem_addr ^ K) : 32'hDEAD_BEEF;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic [31:0] m_ipc;
  bit          m_infl = 1'b0;
  bit          m_live = 1'b0;

  initial forever begin
    @(negedge clk);
    if (m_live) begin
      bit er;
      bit ev;
      er = !rst && !bus.redirect && ((mq.size() + int'(m_infl)) < DEPTH);
      ev = !rst && (mq.size() != 0);
      chk("m_imem_req", 32'(bus.imem_req), 32'(er));
      if (er) chk("m_imem_addr", bus.imem_addr, m_pc);
      chk("m_out_valid", 32'(bus.out_valid), 32'(ev));
      if (ev) begin
        chk("m_out_pc", bus.out_pc, mq[0].pc);
        chk("m_out_instr", bus.out_instr, mq[0].instr);
      end
    end
    @(posedge clk);
    begin
      bit er;
      bit pop;
      er  = !rst && !bus.redirect && ((mq.size() + int'(m_infl)) < DEPTH);
      pop = (mq.size() != 0) && (bus.out_ready === 1'b1);
      if (rst) begin
        m_pc = RESET_PC; mq.delete(); m_infl = 1'b0; m_live = 1'b1;
      end else if (bus.redirect) begin
        m_pc = {bus.redirect_pc[31:2], 2'b00}; mq.delete(); m_infl = 1'b0;
      end else begin
        if (pop) void'(mq.pop_front());
        if (m_infl) mq.push_back('{m_ipc, m_ipc ^ K});
        if (er) begin
          m_ipc = m_pc; m_pc = m_pc + 32'd4; m_infl = 1'b1;
        end else m_infl = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic smp(); @(negedge clk); endtask

  initial begin
    int nreq;
    rst = 1'b1; bus.redirect = 1'b0; bus.redirect_pc = '0; bus.out_ready = 1'b1;
    cyc(); cyc();
    smp();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);

    // Streaming after reset release
    cyc(); rst = 1'b0;
    smp(); chk("s_req0", 32'(bus.imem_req), 32'd1); chk("s_addr0", bus.imem_addr, 32'h0);
    cyc();
    smp(); chk("s_addr1", bus.imem_addr, 32'h4); chk("s_valid1", 32'(bus.out_valid), 32'd0);
    cyc();
    smp(); chk("s_valid2", 32'(bus.out_valid), 32'd1);
    chk("s_pc2", bus.out_pc, 32'h0); chk("s_instr2", bus.out_instr, 32'hA5A5_0000);
    for (int i = 0; i < 6; i++) begin
      cyc(); smp();
      chk("s_stream_valid", 32'(bus.out_valid), 32'd1);
      chk("s_stream_pc", bus.out_pc, 32'(4 * (i + 1)));
    end

    // Backpressure fill and drain
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; bus.out_ready = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (bus.imem_req === 1'b1) begin
        chk("bp_addr", bus.imem_addr, 32'(4 * nreq));
        nreq++;
      end
      cyc();
    end
    chk("bp_nreq", 32'(nreq), 32'd4);
    bus.out_ready = 1'b1;
    smp(); chk("bp_req_hold", 32'(bus.imem_req), 32'd0); chk("bp_pc0", bus.out_pc, 32'h0);
    cyc();
    smp(); chk("bp_resume_req", 32'(bus.imem_req), 32'd1);
    chk("bp_resume_addr", bus.imem_addr, 32'h10); chk("bp_pc1", bus.out_pc, 32'h4);
    cyc(); smp(); chk("bp_pc2", bus.out_pc, 32'h8);
    cyc(); smp(); chk("bp_pc3", bus.out_pc, 32'hC);
    cyc(); smp(); chk("bp_pc4", bus.out_pc, 32'h10);

    // Redirect with 3 queued and one in flight
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; bus.out_ready = 1'b0;
    repeat (4) cyc();
    bus.redirect = 1'b1; bus.redirect_pc = 32'h100;
    smp(); chk("r1_req_sup", 32'(bus.imem_req), 32'd0); chk("r1_valid_pre", 32'(bus.out_valid), 32'd1);
    cyc(); bus.redirect = 1'b0;
    smp(); chk("r1_valid", 32'(bus.out_valid), 32'd0);
    chk("r1_req", 32'(bus.imem_req), 32'd1); chk("r1_addr", bus.imem_addr, 32'h100);
    cyc(); bus.out_ready = 1'b1;
    smp(); chk("r1_valid_gap", 32'(bus.out_valid), 32'd0);
    cyc();
    smp(); chk("r1_first_pc", bus.out_pc, 32'h100); chk("r1_first_instr", bus.out_instr, 32'hA5A5_0100);

    // Redirect to unaligned target coinciding with a transfer
    cyc(); bus.redirect = 1'b1; bus.redirect_pc = 32'h203;
    smp(); chk("r2_xfer_valid", 32'(bus.out_valid), 32'd1);
    cyc(); bus.redirect = 1'b0;
    smp(); chk("r2_addr", bus.imem_addr, 32'h200); chk("r2_valid", 32'(bus.out_valid), 32'd0);
    cyc(); cyc();
    smp(); chk("r2_first_pc", bus.out_pc, 32'h200);

    // Back-to-back redirects
    cyc(); bus.redirect = 1'b1; bus.redirect_pc = 32'h300;
    smp(); chk("bb_req0", 32'(bus.imem_req), 32'd0);
    cyc(); bus.redirect_pc = 32'h400;
    smp(); chk("bb_req1", 32'(bus.imem_req), 32'd0);
    cyc(); bus.redirect = 1'b0;
    smp(); chk("bb_addr", bus.imem_addr, 32'h400); chk("bb_valid", 32'(bus.out_valid), 32'd0);

    // Address wrap at the top of the space
    cyc(); bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    cyc(); bus.redirect = 1'b0;
    smp(); chk("w_addr0", bus.imem_addr, 32'hFFFF_FFF8);
    cyc(); smp(); chk("w_addr1", bus.imem_addr, 32'hFFFF_FFFC);
    cyc(); smp(); chk("w_addr2", bus.imem_addr, 32'h0); chk("w_req2", 32'(bus.imem_req), 32'd1);
    chk("w_pc", bus.out_pc, 32'hFFFF_FFF8);

    // One-cycle reset with a full queue
    cyc(); bus.out_ready = 1'b0;
    repeat (8) cyc();
    smp(); chk("fr_full_valid", 32'(bus.out_valid), 32'd1); chk("fr_full_req", 32'(bus.imem_req), 32'd0);
    cyc(); rst = 1'b1;
    smp(); chk("fr_rst_req", 32'(bus.imem_req), 32'd0);
    cyc(); rst = 1'b0; bus.out_ready = 1'b1;
    smp(); chk("fr_valid", 32'(bus.out_valid), 32'd0);
    chk("fr_req", 32'(bus.imem_req), 32'd1); chk("fr_addr", bus.imem_addr, RESET_PC);
    cyc(); cyc();
    smp(); chk("fr_first_pc", bus.out_pc, RESET_PC);
    repeat (4) cyc();

    smp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
